// File: rtl/rob_ctrl.sv
// rob_ctrl: control block in front of the ROB.
//  - Round-robin arbitration of two completion sources (0 = ALU, 1 = LSU)
//    onto the ROB's single mark-ready port, through one register stage.
//  - Shadow ROB head tracking and the flush sequence on a committed
//    exception: IDLE -> FLUSH (1 cycle) -> RECOVER (RECOVER_CYCLES) -> IDLE.
// Optional feature: define ROB_CTRL_PERF_EN to add the perf_commits,
// perf_flushes and perf_conflicts 32-bit wrapping counters and their ports.

module rob_ctrl #(
  parameter int  ROB_SIZE       = 16,
  parameter int  ISSUE_W        = 2,
  parameter int  RECOVER_CYCLES = 3,
  localparam int IDX_BITS       = $clog2(ROB_SIZE)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            cmp_valid,
  input  logic [2*IDX_BITS-1:0] cmp_idx,
  input  logic [1:0]            cmp_exc,
  output logic [1:0]            cmp_ready,
  output logic                  mark_ready_en,
  output logic [IDX_BITS-1:0]   mark_ready_idx,
  output logic                  mark_ready_val,
  output logic                  mark_exception,
  input  logic [ISSUE_W-1:0]    commit_valid,
  input  logic [ISSUE_W-1:0]    commit_exception,
  output logic                  flush_en,
  output logic [IDX_BITS-1:0]   flush_ptr,
  output logic                  stall_dispatch,
  output logic                  kill_inflight,
  output logic                  exc_pulse
`ifdef ROB_CTRL_PERF_EN
  ,
  output logic [31:0]           perf_commits,
  output logic [31:0]           perf_flushes,
  output logic [31:0]           perf_conflicts
`endif
);

  // Width of a commit popcount (0..ISSUE_W).
  localparam int CNT_W = $clog2(ISSUE_W + 1);
  // The recover counter holds RECOVER_CYCLES-1 down to 0.
  localparam int RC_W = (RECOVER_CYCLES > 1) ? $clog2(RECOVER_CYCLES) : 1;
  localparam logic [RC_W-1:0]     RC_LOAD      = RC_W'(RECOVER_CYCLES - 1);
  localparam logic [RC_W-1:0]     RC_ZERO      = RC_W'(0);
  localparam logic [RC_W-1:0]     RC_ONE       = RC_W'(1);
  localparam logic [IDX_BITS:0]   ROB_SIZE_EXT = (IDX_BITS + 1)'(ROB_SIZE);
  localparam logic [IDX_BITS-1:0] IDX_ZERO     = IDX_BITS'(0);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FLUSH   = 2'd1,
    ST_RECOVER = 2'd2
  } state_e;

  // Number of valid commit slots this cycle.
  function automatic logic [CNT_W-1:0] popcount(input logic [ISSUE_W-1:0] vec);
    logic [CNT_W-1:0] cnt;
    cnt = CNT_W'(0);
    for (int j = 0; j < ISSUE_W; j++) begin
      cnt = cnt + CNT_W'(vec[j]);
    end
    return cnt;
  endfunction

  // ROB pointer advance with wrap at ROB_SIZE (works for any depth, not
  // only powers of two; inc never exceeds ISSUE_W <= ROB_SIZE).
  function automatic logic [IDX_BITS-1:0] wrap_add(input logic [IDX_BITS-1:0] base,
                                                   input logic [CNT_W-1:0]    inc);
    logic [IDX_BITS:0] sum;
    sum = {1'b0, base} + (IDX_BITS + 1)'(inc);
    if (sum >= ROB_SIZE_EXT) begin
      sum = sum - ROB_SIZE_EXT;
    end else begin
      sum = sum;
    end
    return sum[IDX_BITS-1:0];
  endfunction

  // State and registered outputs
  state_e              state_q, state_d;
  logic [RC_W-1:0]     rc_cnt_q, rc_cnt_d;
  logic                rr_q, rr_d;
  logic [IDX_BITS-1:0] head_q, head_d;
  logic                mark_en_q, mark_en_d;
  logic [IDX_BITS-1:0] mark_idx_q, mark_idx_d;
  logic                mark_exc_q, mark_exc_d;
  logic                flush_en_q, flush_en_d;
  logic [IDX_BITS-1:0] flush_ptr_q, flush_ptr_d;
  logic                stall_q, stall_d;
  logic                kill_q, kill_d;
  logic                exc_pulse_q, exc_pulse_d;

  // Combinational helpers
  logic [CNT_W-1:0]    pop_s;
  logic                exc_commit_s;
  logic                arb_en_s;
  logic [1:0]          grant_s;
  logic [IDX_BITS-1:0] head_next_s;

  // Arbitration, FSM next-state, head tracking and next values of all outputs.
  always_comb begin
    pop_s        = popcount(commit_valid);
    head_next_s  = wrap_add(head_q, pop_s);
    exc_commit_s = (state_q == ST_IDLE) && ((commit_valid & commit_exception) != {ISSUE_W{1'b0}});
    // A committing exception wins over completions: nothing is granted
    // in the detect cycle so no mark can leak into the flush.
    arb_en_s     = (state_q == ST_IDLE) && !exc_commit_s && !reset;

    grant_s = 2'b00;
    rr_d    = rr_q;
    if (arb_en_s) begin
      case (cmp_valid)
        2'b01:   grant_s = 2'b01;
        2'b10:   grant_s = 2'b10;
        2'b11: begin
          grant_s = rr_q ? 2'b10 : 2'b01;
          rr_d    = ~rr_q;
        end
        default: grant_s = 2'b00;
      endcase
    end else begin
      grant_s = 2'b00;
    end

    state_d     = state_q;
    rc_cnt_d    = rc_cnt_q;
    head_d      = head_q;
    flush_ptr_d = flush_ptr_q;
    case (state_q)
      ST_IDLE: begin
        head_d = head_next_s;
        if (exc_commit_s) begin
          state_d     = ST_FLUSH;
          flush_ptr_d = head_next_s;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_FLUSH: begin
        // Commits are ignored from here on; realign to the flushed head.
        head_d   = flush_ptr_q;
        state_d  = ST_RECOVER;
        rc_cnt_d = RC_LOAD;
      end
      ST_RECOVER: begin
        if (rc_cnt_q == RC_ZERO) begin
          state_d = ST_IDLE;
        end else begin
          rc_cnt_d = rc_cnt_q - RC_ONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    mark_en_d = (grant_s != 2'b00);
    if (grant_s[1]) begin
      mark_idx_d = cmp_idx[IDX_BITS +: IDX_BITS];
      mark_exc_d = cmp_exc[1];
    end else if (grant_s[0]) begin
      mark_idx_d = cmp_idx[0 +: IDX_BITS];
      mark_exc_d = cmp_exc[0];
    end else begin
      mark_idx_d = IDX_ZERO;
      mark_exc_d = 1'b0;
    end

    flush_en_d  = (state_q == ST_IDLE) && (state_d == ST_FLUSH);
    kill_d      = flush_en_d;
    exc_pulse_d = flush_en_d;
    stall_d     = (state_d != ST_IDLE);
  end

  // All state and registered outputs; synchronous reset clears everything,
  // which also abandons any flush sequence in progress.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      rc_cnt_q    <= RC_ZERO;
      rr_q        <= 1'b0;
      head_q      <= IDX_ZERO;
      mark_en_q   <= 1'b0;
      mark_idx_q  <= IDX_ZERO;
      mark_exc_q  <= 1'b0;
      flush_en_q  <= 1'b0;
      flush_ptr_q <= IDX_ZERO;
      stall_q     <= 1'b0;
      kill_q      <= 1'b0;
      exc_pulse_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rc_cnt_q    <= rc_cnt_d;
      rr_q        <= rr_d;
      head_q      <= head_d;
      mark_en_q   <= mark_en_d;
      mark_idx_q  <= mark_idx_d;
      mark_exc_q  <= mark_exc_d;
      flush_en_q  <= flush_en_d;
      flush_ptr_q <= flush_ptr_d;
      stall_q     <= stall_d;
      kill_q      <= kill_d;
      exc_pulse_q <= exc_pulse_d;
    end
  end

  assign cmp_ready      = grant_s;
  assign mark_ready_en  = mark_en_q;
  assign mark_ready_idx = mark_idx_q;
  assign mark_ready_val = mark_en_q;
  assign mark_exception = mark_exc_q;
  assign flush_en       = flush_en_q;
  assign flush_ptr      = flush_ptr_q;
  assign stall_dispatch = stall_q;
  assign kill_inflight  = kill_q;
  assign exc_pulse      = exc_pulse_q;

`ifdef ROB_CTRL_PERF_EN
  logic [31:0] perf_commits_q;
  logic [31:0] perf_flushes_q;
  logic [31:0] perf_conflicts_q;

  // Wrapping event counters: commits, flush entries, contested IDLE cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_commits_q   <= 32'd0;
      perf_flushes_q   <= 32'd0;
      perf_conflicts_q <= 32'd0;
    end else begin
      perf_commits_q <= perf_commits_q + 32'(pop_s);
      if (flush_en_d) begin
        perf_flushes_q <= perf_flushes_q + 32'd1;
      end else begin
        perf_flushes_q <= perf_flushes_q;
      end
      if ((state_q == ST_IDLE) && (cmp_valid == 2'b11)) begin
        perf_conflicts_q <= perf_conflicts_q + 32'd1;
      end else begin
        perf_conflicts_q <= perf_conflicts_q;
      end
    end
  end

  assign perf_commits   = perf_commits_q;
  assign perf_flushes   = perf_flushes_q;
  assign perf_conflicts = perf_conflicts_q;
`endif

endmodule

// File: tb/tb_rob_ctrl.sv
// Self-checking bench for rob_ctrl: directed scenarios followed by random
// traffic, compared against a cycle-level behavioural model.
module tb_rob_ctrl;

  localparam int ROB_N = 16;
  localparam int RC    = 3;

  logic       clk;
  logic       reset;
  logic [1:0] cmp_valid;
  logic [7:0] cmp_idx;
  logic [1:0] cmp_exc;
  logic [1:0] cmp_ready;
  logic       mark_ready_en;
  logic [3:0] mark_ready_idx;
  logic       mark_ready_val;
  logic       mark_exception;
  logic [1:0] commit_valid;
  logic [1:0] commit_exception;
  logic       flush_en;
  logic [3:0] flush_ptr;
  logic       stall_dispatch;
  logic       kill_inflight;
  logic       exc_pulse;
`ifdef ROB_CTRL_PERF_EN
  logic [31:0] perf_commits;
  logic [31:0] perf_flushes;
  logic [31:0] perf_conflicts;
`endif

  rob_ctrl #(.ROB_SIZE(ROB_N), .ISSUE_W(2), .RECOVER_CYCLES(RC)) dut (
    .clk              (clk),
    .reset            (reset),
    .cmp_valid        (cmp_valid),
    .cmp_idx          (cmp_idx),
    .cmp_exc          (cmp_exc),
    .cmp_ready        (cmp_ready),
    .mark_ready_en    (mark_ready_en),
    .mark_ready_idx   (mark_ready_idx),
    .mark_ready_val   (mark_ready_val),
    .mark_exception   (mark_exception),
    .commit_valid     (commit_valid),
    .commit_exception (commit_exception),
    .flush_en         (flush_en),
    .flush_ptr        (flush_ptr),
    .stall_dispatch   (stall_dispatch),
    .kill_inflight    (kill_inflight),
    .exc_pulse        (exc_pulse)
`ifdef ROB_CTRL_PERF_EN
    ,
    .perf_commits     (perf_commits),
    .perf_flushes     (perf_flushes),
    .perf_conflicts   (perf_conflicts)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: busy = cycles left with dispatch stalled (0 = idle),
  // head/ptr as plain integers, rr = preferred source under contention.
  int   m_busy, m_head, m_rr, m_ptr;
  logic e_mark_en, e_mark_exc, e_flush, e_stall;
  int   e_mark_idx, e_ptr;
  int   p_commits, p_flushes, p_conflicts;
  logic [1:0] last_ready;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_head = 0; m_rr = 0; m_ptr = 0;
    e_mark_en = 1'b0; e_mark_exc = 1'b0; e_mark_idx = 0;
    e_flush = 1'b0; e_stall = 1'b0; e_ptr = 0;
    p_commits = 0; p_flushes = 0; p_conflicts = 0;
  endtask

  // One clock cycle: apply inputs, check outputs, advance the model.
  task automatic run_cycle(input logic rst, input logic [1:0] cv,
                           input logic [3:0] i0, input logic [3:0] i1,
                           input logic [1:0] cx, input logic [1:0] kv,
                           input logic [1:0] ke);
    bit         idle, exc_now;
    int         win;
    logic [1:0] exp_ready;
    reset = rst; cmp_valid = cv; cmp_idx = {i1, i0}; cmp_exc = cx;
    commit_valid = kv; commit_exception = ke;
    #1;
    idle    = (m_busy == 0);
    exc_now = !rst && idle && ((kv & ke) != 2'b00);
    win = -1;
    if (!rst && idle && !exc_now) begin
      if (cv == 2'b11) win = m_rr;
      else if (cv == 2'b01) win = 0;
      else if (cv == 2'b10) win = 1;
    end
    exp_ready = (win == 0) ? 2'b01 : (win == 1) ? 2'b10 : 2'b00;
    chk("cmp_ready", cmp_ready, exp_ready);
    last_ready = cmp_ready;
    chk("mark_en", mark_ready_en, e_mark_en);
    chk("mark_val", mark_ready_val, e_mark_en);
    if (e_mark_en) begin
      chk("mark_idx", mark_ready_idx, e_mark_idx);
      chk("mark_exc", mark_exception, e_mark_exc);
    end
    chk("flush_en", flush_en, e_flush);
    chk("kill", kill_inflight, e_flush);
    chk("exc_pulse", exc_pulse, e_flush);
    chk("stall", stall_dispatch, e_stall);
    if (e_flush) chk("flush_ptr", flush_ptr, e_ptr);
`ifdef ROB_CTRL_PERF_EN
    chk("perf_commits", perf_commits, p_commits);
    chk("perf_flushes", perf_flushes, p_flushes);
    chk("perf_conflicts", perf_conflicts, p_conflicts);
`endif
    if (rst) begin
      model_reset();
    end else begin
      e_mark_en = (win >= 0);
      if (win >= 0) begin
        e_mark_idx = (win == 1) ? int'(i1) : int'(i0);
        e_mark_exc = cx[win];
        if (cv == 2'b11) m_rr = 1 - m_rr;
      end
      p_commits   += $countones(kv);
      p_flushes   += exc_now ? 1 : 0;
      p_conflicts += (idle && cv == 2'b11) ? 1 : 0;
      if (idle) begin
        m_head = (m_head + $countones(kv)) % ROB_N;
        if (exc_now) begin
          m_ptr  = m_head;
          m_busy = RC + 1;
        end
      end else begin
        if (m_busy == RC + 1) m_head = m_ptr;
        m_busy--;
      end
      e_flush = exc_now;
      e_ptr   = m_ptr;
      e_stall = (m_busy > 0);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; cmp_valid = 2'b00; cmp_idx = 8'h00; cmp_exc = 2'b00;
    commit_valid = 2'b00; commit_exception = 2'b00;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ptr", flush_ptr, 32'd0);
    chk("rst_stall", stall_dispatch, 32'd0);
    run_cycle(1'b1, 2'b11, 4'd1, 4'd2, 2'b00, 2'b00, 2'b00);

    // Single ALU completion
    run_cycle(1'b0, 2'b01, 4'd5, 4'd0, 2'b00, 2'b00, 2'b00);
    chk("t1_ready", last_ready, 32'h1);
    chk("t1_en", mark_ready_en, 32'd1);
    chk("t1_idx", mark_ready_idx, 32'd5);
    chk("t1_exc", mark_exception, 32'd0);
    run_cycle(1'b0, 2'b00, 4'd0, 4'd0, 2'b00, 2'b00, 2'b00);

    // Contention alternates 0,1,0,1
    for (int k = 0; k < 4; k++) begin
      run_cycle(1'b0, 2'b11, 4'd3, 4'd7, 2'b00, 2'b00, 2'b00);
      chk("t2_ready", last_ready, (k % 2 == 1) ? 32'h2 : 32'h1);
      chk("t2_idx", mark_ready_idx, (k % 2 == 1) ? 32'd7 : 32'd3);
    end
    run_cycle(1'b0, 2'b00, 4'd0, 4'd0, 2'b00, 2'b00, 2'b00);

    // Head to 5, then exception with both slots committing -> ptr 7
    run_cycle(1'b0, 2'b00, 4'd0, 4'd0, 2'b00, 2'b11, 2'b00);
    run_cycle(1'b0, 2'b00, 4'd0, 4'd0, 2'b00, 2'b11, 2'b00);
    run_cycle(1'b0, 2'b00, 4'd0, 4'd0, 2'b00, 2'b01, 2'b00);
    run_cycle(1'b0, 2'b00, 4'd0, 4'd0, 2'b00, 2'b11, 2'b01);
    chk("t3_flush", flush_en, 32'd1);
    chk("t3_ptr", flush_ptr, 32'd7);
    chk("t3_pulse", exc_pulse, 32'd1);
    chk("t3_kill", kill_inflight, 32'd1);
    for (int k = 0; k < 4; k++) begin
      run_cycle(1'b0, 2'b11, 4'd1, 4'd2, 2'b00, 2'b11, 2'b00);
      chk("t4_ready", last_ready, 32'h0);
      chk("t4_stall", stall_dispatch, (k < 3) ? 32'd1 : 32'd0);
    end
    // Back in IDLE: contested grant to source 0, leaves preference on 1
    run_cycle(1'b0, 2'b11, 4'd4, 4'd6, 2'b00, 2'b00, 2'b00);
    chk("t4_idle_ready", last_ready, 32'h1);

    // Head 7 -> 15, then exception on slot 1 wraps ptr to 1
    for (int k = 0; k < 4; k++) run_cycle(1'b0, 2'b00, 4'd0, 4'd0, 2'b00, 2'b11, 2'b00);
    run_cycle(1'b0, 2'b00, 4'd0, 4'd0, 2'b00, 2'b11, 2'b10);
    chk("t5_ptr", flush_ptr, 32'd1);
    chk("t5_flush", flush_en, 32'd1);

    // Reset during the second RECOVER cycle
    run_cycle(1'b0, 2'b00, 4'd0, 4'd0, 2'b00, 2'b00, 2'b00);
    run_cycle(1'b0, 2'b00, 4'd0, 4'd0, 2'b00, 2'b00, 2'b00);
    run_cycle(1'b1, 2'b00, 4'd0, 4'd0, 2'b00, 2'b00, 2'b00);
    chk("t6_stall", stall_dispatch, 32'd0);
    chk("t6_flush", flush_en, 32'd0);
    run_cycle(1'b0, 2'b11, 4'd9, 4'd10, 2'b00, 2'b00, 2'b00);
    chk("t6_ready", last_ready, 32'h1);
    run_cycle(1'b0, 2'b00, 4'd0, 4'd0, 2'b00, 2'b01, 2'b01);
    chk("t6_head_ptr", flush_ptr, 32'd1);
    for (int k = 0; k < 5; k++) run_cycle(1'b0, 2'b00, 4'd0, 4'd0, 2'b00, 2'b00, 2'b00);

    // Random traffic
    for (int n = 0; n < 2000; n++) begin
      logic       r_rst;
      logic [1:0] r_ke;
      r_rst = ($urandom_range(0, 199) == 0);
      r_ke  = ($urandom_range(0, 11) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      run_cycle(r_rst, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
                4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
                2'($urandom_range(0, 3)), r_ke);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
